// File: rtl/branch_recovery_unit.sv
// branch_recovery_unit: holds resolved branch mispredictions until the branch
// retires at the ROB head, then issues a one-cycle flush, presents the
// redirect PC to fetch until it is accepted, and finishes with a fixed drain
// window.
// Optional feature macro: BRANCH_RECOVERY_PERF_EN (adds flush_count/drop_count).
module branch_recovery_unit #(
  parameter int DEPTH        = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int XLEN         = 32,
  parameter int ROB_TAG_LEN  = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   bu_done,
  input  logic                   bu_cond,
  input  logic [XLEN-1:0]        bu_target_pc,
  input  logic [ROB_TAG_LEN-1:0] bu_insn_tag,
  output logic                   bu_ready,
  input  logic                   rob_head_retire,
  input  logic [ROB_TAG_LEN-1:0] rob_head_tag,
  input  logic                   fetch_ready,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   busy,
  output logic                   overflow
`ifdef BRANCH_RECOVERY_PERF_EN
  ,
  output logic [31:0]            flush_count,
  output logic [31:0]            drop_count
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT, S_DRAIN} state_t;

  state_t                 state;
  logic [3:0]             drain_cnt;
  logic [DEPTH-1:0]       ent_valid;
  logic [ROB_TAG_LEN-1:0] ent_tag    [DEPTH];
  logic [XLEN-1:0]        ent_target [DEPTH];

  logic                   push_req;
  logic                   bypass;
  logic                   hit_any;
  logic [IW-1:0]          hit_idx;
  logic                   free_any;
  logic [IW-1:0]          free_idx;
  logic                   ret_any;
  logic [XLEN-1:0]        ret_pc;
  logic                   match_hit;
  logic [XLEN-1:0]        match_pc;
  logic                   push_idle;
  logic                   push_ok;
  logic [IW-1:0]          wr_idx;
  logic                   drop_full;
  logic                   drop_any;

  // Associative lookups: lowest index wins (descending loop, last write wins).
  always_comb begin
    hit_any  = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    ret_any  = 1'b0;
    ret_pc   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_tag[i] == bu_insn_tag)) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (!ent_valid[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_valid[i] && (ent_tag[i] == rob_head_tag)) begin
        ret_any = 1'b1;
        ret_pc  = ent_target[i];
      end
    end
  end

  // Push/match decode. A push in the same cycle as a match is squashed along
  // with everything else younger than the retiring branch.
  always_comb begin
    push_req  = bu_done && bu_cond;
    bypass    = push_req && rob_head_retire && (bu_insn_tag == rob_head_tag);
    match_hit = (state == S_IDLE) && rob_head_retire && (bypass || ret_any);
    match_pc  = bypass ? bu_target_pc : ret_pc;
    push_idle = (state == S_IDLE) && push_req && !match_hit;
    push_ok   = push_idle && (hit_any || free_any);
    wr_idx    = hit_any ? hit_idx : free_idx;
    drop_full = push_idle && !hit_any && !free_any;
    drop_any  = drop_full || (push_req && (state != S_IDLE));
  end

  assign bu_ready = (state == S_IDLE) && !(&ent_valid);

  // Pending-misprediction table and sticky overflow flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ent_valid <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_tag[i]    <= '0;
        ent_target[i] <= '0;
      end
    end else begin
      if (match_hit) begin
        ent_valid <= '0;
      end else if (push_ok) begin
        ent_valid[wr_idx]  <= 1'b1;
        ent_tag[wr_idx]    <= bu_insn_tag;
        ent_target[wr_idx] <= bu_target_pc;
      end
      if (drop_full) overflow <= 1'b1;
    end
  end

  // Recovery sequencer with registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      drain_cnt      <= 4'd0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (match_hit) begin
            state          <= S_FLUSH;
            redirect_pc    <= match_pc;
            flush          <= 1'b1;
            redirect_valid <= 1'b1;
            busy           <= 1'b1;
          end
        end
        S_FLUSH, S_REDIRECT: begin
          flush <= 1'b0;
          if (fetch_ready) begin
            redirect_valid <= 1'b0;
            if (DRAIN_CYCLES == 0) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRAIN_LOAD;
            end
          end else begin
            state <= S_REDIRECT;
          end
        end
        S_DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            state     <= S_IDLE;
            drain_cnt <= 4'd0;
            busy      <= 1'b0;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef BRANCH_RECOVERY_PERF_EN
  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_count <= 32'd0;
      drop_count  <= 32'd0;
    end else begin
      if (state == S_FLUSH) flush_count <= flush_count + 32'd1;
      if (drop_any) drop_count <= drop_count + 32'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop_any;
`endif

endmodule

// File: doc/branch_recovery_unit.md
# branch_recovery_unit

Receives resolved mispredictions from the branch functional unit and holds them until the branch retires. When the mispredicted branch reaches the ROB head and retires, it issues a one-cycle pipeline flush. It then drives a held redirect PC to fetch, followed by a fixed drain window. It sits between the branch unit's result port, the ROB commit head and the fetch stage.

## Interface
- `DEPTH`, 4: pending-misprediction entries, 2..16.
- `DRAIN_CYCLES`, 2: post-redirect quiet cycles, 0..15.
- `clock`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `bu_done`  in  1  branch unit result valid this cycle.
- `bu_cond`  in  1  1 = mispredict/flush required.
- `bu_target_pc`  in  `XLEN`  correct next PC.
- `bu_insn_tag`  in  `ROB_TAG_LEN`  ROB tag of the branch.
- `bu_ready`  out  1  a free entry exists and state is IDLE.
- `rob_head_retire`  in  1  ROB head retires this cycle.
- `rob_head_tag`  in  `ROB_TAG_LEN`  tag of the retiring head.
- `fetch_ready`  in  1  fetch accepts the redirect this cycle.
- `flush`  out  1  one-cycle squash of all speculative state.
- `redirect_valid`  out  1  redirect PC is valid.
- `redirect_pc`  out  `XLEN`  fetch target.
- `busy`  out  1  state is not IDLE.
- `overflow`  out  1  sticky: push dropped while full.

## Operation
- Storage: `DEPTH` entries {valid, tag, target}. Tag lookup is fully associative.
- Push: `bu_done && bu_cond` in IDLE. Write to the lowest-index free entry. If a valid entry already has the same tag, overwrite that entry instead (no duplicate).
- `bu_done && !bu_cond`: ignored.
- Push while full with no tag match: dropped, and `overflow` is set. `overflow` clears only on reset.
- Push outside IDLE: dropped silently, because the pipeline is being squashed. It does not set `overflow`.
- Match: in IDLE, `rob_head_retire` and a valid entry with tag == `rob_head_tag`. The matched target is latched into `redirect_pc`, all entries are invalidated, and the next state is FLUSH.
- Bypass: if a push and a retire carry the same tag in the same cycle, the incoming `bu_target_pc` is used and no entry is written.
- Retire with no match: no effect.
- FSM:
  - IDLE→FLUSH on match.
  - FLUSH: `flush`=1 and `redirect_valid`=1. If `fetch_ready`=1, go to DRAIN (or IDLE if `DRAIN_CYCLES`=0). Otherwise go to REDIRECT.
  - REDIRECT: `redirect_valid`=1 with `redirect_pc` held stable. Leave when `fetch_ready` is sampled 1, using the same next-state rule as FLUSH.
  - DRAIN: 4-bit down-counter loaded with `DRAIN_CYCLES`. Return to IDLE when it reaches 1.
- `bu_ready` = IDLE && any entry invalid (combinational).

## Timing
- Reset (asynchronous, any state): all entries invalid, state IDLE, counter 0, `redirect_pc`=0. Outputs: `flush`=0, `redirect_valid`=0, `busy`=0, `overflow`=0, `bu_ready`=1. Reset mid-recovery abandons the redirect.
- Push to entry visible: 1 cycle (registered).
- Retire match in cycle N → `flush` and `redirect_valid` both 1 in cycle N+1.
  - `flush` is high for exactly one cycle per match.
  - `redirect_valid` is high from cycle N+1 through the first cycle in which `fetch_ready`=1.
- `busy` is 1 from N+1 through the final DRAIN cycle. Total busy cycles = redirect cycles + `DRAIN_CYCLES`.
- The next match can be accepted in the first IDLE cycle after busy.
- All outputs except `bu_ready` are registered.

## Configuration
- `BRANCH_RECOVERY_PERF_EN` defined:
  - adds output `flush_count` (32 bits, reset 0), incremented on every FLUSH cycle and wrapping at 2^32;
  - adds output `drop_count` (32 bits, reset 0), incremented on every dropped push, whether dropped for full or for non-IDLE.
- Undefined: neither port nor either counter exists. Behaviour is otherwise identical.

## Test plan
- Push tag 5, target 0x1000. Retire tag 5 with `fetch_ready`=1 → next cycle `flush`=1, `redirect_valid`=1, `redirect_pc`=0x1000. Then `busy` stays 1 for two more cycles. Then `bu_ready`=1.
- Push tags 3 (0x200) and 7 (0x300). Retire tag 7 → redirect 0x300. Entry 3 is invalidated, so a later retire of tag 3 produces no flush.
- Hold `fetch_ready`=0 for 4 cycles after the match → `flush` high for 1 cycle only. `redirect_valid` stays high for 5 cycles with `redirect_pc` stable.
- Fill all 4 entries → `bu_ready`=0. A fifth push with a new tag sets `overflow`=1. A push to an existing tag overwrites that entry's target and does not set `overflow`.
- Push and retire tag 9 in the same cycle with target 0x44 → flush next cycle with `redirect_pc`=0x44, and no entry is left valid.
- Deassert `reset_n` during REDIRECT → all outputs return to reset values immediately, with no clock edge needed. `bu_ready`=1.
